// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready payload handshake bundle for pipe_stage_skid
//
// Purpose: one direction of a valid/ready stream between pipeline stages.
// Signals:
//   data   WIDTH  payload, bit 0 is the MSB (ascending range)
//   valid  1      producer holds a valid payload
//   ready  1      consumer accepts this cycle
// Modports:
//   master  producer side (drives data/valid, samples ready)
//   slave   consumer side (samples data/valid, drives ready)
interface pipe_stage_skid_if #(
  parameter int WIDTH = 172
);
  logic [0:WIDTH-1] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - generic-width pipeline stage register with 2-entry skid buffer
//
// Purpose: inter-stage register with a registered upstream ready, a
// 2-entry FIFO (main + skid), synchronous flush and saturating
// bubble/stall performance counters.
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-low reset
//   in_if       slave stream from the upstream stage (ready = !skid_valid, registered)
//   out_if      master stream to the downstream stage (data = BUBBLE_VAL when not valid)
//   flush       synchronous kill of all held entries
//   clr_cnt     synchronous clear of both counters
//   occupancy   number of held entries (0..2)
//   bubble_cnt  cycles with downstream ready and no valid output
//   stall_cnt   cycles with valid output and downstream not ready
module pipe_stage_skid #(
  parameter int               WIDTH      = 172,
  parameter logic [0:WIDTH-1] BUBBLE_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  pipe_stage_skid_if.slave         in_if,
  pipe_stage_skid_if.master        out_if,
  input  logic                     flush,
  input  logic                     clr_cnt,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [0:WIDTH-1] main_q, main_d;
  logic [0:WIDTH-1] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic main_valid;
  logic skid_valid;
  logic push;
  logic pop;

  // Valids are encoded in the state: skid is only ever occupied behind main.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);
  assign push       = in_if.valid & in_ready_q;
  assign pop        = main_valid & out_if.ready;

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = main_valid;
  assign out_if.data  = main_valid ? main_q : BUBBLE_VAL;
  assign occupancy    = state_q;
  assign bubble_cnt   = bubble_q;
  assign stall_cnt    = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    // Flush empties the stage; a concurrent pop has already been taken by
    // downstream and a concurrent push is simply dropped.
    if (!flush) begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_if.data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_if.data;
          end else if (push) begin
            state_d = TWO;
            skid_d  = in_if.data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end

    // Registered ready: look ahead at next occupancy so back-pressure
    // never depends combinationally on out_ready.
    in_ready_d = (state_d != TWO);
  end

  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (clr_cnt) begin
      bubble_d = '0;
      stall_d  = '0;
    end else begin
      if (out_if.ready && !main_valid && (bubble_q != CNT_MAX)) begin
        bubble_d = bubble_q + CNT_ONE;
      end
      if (main_valid && !out_if.ready && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b0;
      bubble_q   <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      bubble_q   <= bubble_d;
      stall_q    <= stall_d;
    end
  end

  // skid_valid documents the storage model; occupancy already reflects it.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int W  = 172;
  localparam int W2 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_skid_if #(.WIDTH(W))  up_if ();
  pipe_stage_skid_if #(.WIDTH(W))  dn_if ();
  pipe_stage_skid_if #(.WIDTH(W2)) up2_if ();
  pipe_stage_skid_if #(.WIDTH(W2)) dn2_if ();

  logic        flush, clr_cnt;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt, stall_cnt;

  logic        flush2, clr2;
  logic [1:0]  occ2;
  logic [1:0]  bubble2, stall2;

  pipe_stage_skid #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .in_if(up_if), .out_if(dn_if),
    .flush(flush), .clr_cnt(clr_cnt), .occupancy(occupancy),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.WIDTH(W2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst_n), .in_if(up2_if), .out_if(dn2_if),
    .flush(flush2), .clr_cnt(clr2), .occupancy(occ2),
    .bubble_cnt(bubble2), .stall_cnt(stall2)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [0:W-1] sb_q[$];
  logic [0:W-1] pat_a5;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven: scores the handshakes
  // of the coming edge, then advances one cycle.
  task automatic step();
    logic         push, pop;
    logic [0:W-1] exp_d;
    push = up_if.valid && up_if.ready;
    pop  = dn_if.valid && dn_if.ready;
    if (pop) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_unexpected_pop: observed %0h expected none", dn_if.data);
      end else begin
        exp_d = sb_q.pop_front();
        chk("sb_data", dn_if.data, exp_d);
      end
    end
    if (flush) sb_q.delete();
    else if (push) sb_q.push_back(up_if.data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    pat_a5       = {4'hA, {21{8'hA5}}};
    up_if.valid  = 1'b0;
    up_if.data   = '0;
    dn_if.ready  = 1'b0;
    flush        = 1'b0;
    clr_cnt      = 1'b0;
    up2_if.valid = 1'b0;
    up2_if.data  = '0;
    dn2_if.ready = 1'b0;
    flush2       = 1'b0;
    clr2         = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", up_if.ready, 0);
    chk("rst_out_valid", dn_if.valid, 0);
    chk("rst_out_data", dn_if.data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", up_if.ready, 1);

    // First push from EMPTY: one-cycle latency, one bubble cycle
    up_if.valid = 1'b1;
    up_if.data  = pat_a5;
    dn_if.ready = 1'b1;
    step();
    up_if.valid = 1'b0;
    chk("t1_out_valid", dn_if.valid, 1);
    chk("t1_out_data", dn_if.data, pat_a5);
    chk("t1_occupancy", occupancy, 1);
    chk("t1_bubble", bubble_cnt, 1);
    step();

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = W'(i);
      chk("t2_in_ready", up_if.ready, 1);
      if (i > 1) chk("t2_out_valid", dn_if.valid, 1);
      step();
    end
    up_if.valid = 1'b0;
    chk("t2_last_valid", dn_if.valid, 1);
    step();
    chk("t2_stall", stall_cnt, 0);
    chk("t2_drained", occupancy, 0);

    // Back-pressure fills the skid, then drains in order
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = W'(1);
    step();
    chk("t3_occ_one", occupancy, 1);
    chk("t3_ready_one", up_if.ready, 1);
    up_if.data = W'(2);
    step();
    chk("t3_occ_two", occupancy, 2);
    chk("t3_ready_two", up_if.ready, 0);
    up_if.data = W'(3);
    step();
    chk("t3_occ_hold", occupancy, 2);
    dn_if.ready = 1'b1;
    step();
    step();
    up_if.valid = 1'b0;
    step();
    chk("t3_stall", stall_cnt, 2);
    chk("t3_occ_empty", occupancy, 0);

    // Flush from TWO with a concurrent push and pop
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = W'(8'h11);
    step();
    up_if.data = W'(8'h22);
    step();
    chk("t4_occ_two", occupancy, 2);
    flush       = 1'b1;
    up_if.data  = W'(8'h77);
    dn_if.ready = 1'b1;
    step();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    chk("t4_occ", occupancy, 0);
    chk("t4_out_valid", dn_if.valid, 0);
    chk("t4_out_data", dn_if.data, 0);
    chk("t4_in_ready", up_if.ready, 1);
    chk("t4_stall_kept", stall_cnt, 3);
    repeat (3) step();

    // Counter saturation and clear on the CNT_W=2 instance
    up2_if.valid = 1'b1;
    up2_if.data  = 8'h5A;
    @(posedge clk);
    #1;
    up2_if.valid = 1'b0;
    chk("t5_data", dn2_if.data, 8'h5A);
    chk("t5_stall0", stall2, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_stall2", stall2, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_sat", stall2, 3);
    clr2 = 1'b1;
    @(posedge clk);
    #1;
    clr2 = 1'b0;
    chk("t5_clr", stall2, 0);
    @(posedge clk);
    #1;
    chk("t5_resume", stall2, 1);

    // Asynchronous reset while in TWO
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = W'(8'hC1);
    step();
    up_if.data = W'(8'hC2);
    step();
    up_if.valid = 1'b0;
    chk("t6_occ_two", occupancy, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", dn_if.valid, 0);
    chk("t6_async_occ", occupancy, 0);
    chk("t6_async_ready", up_if.ready, 0);
    chk("t6_async_stall", stall_cnt, 0);
    sb_q.delete();
    dn_if.ready = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_ready", up_if.ready, 1);
    up_if.valid = 1'b1;
    up_if.data  = W'(8'hD1);
    step();
    up_if.valid = 1'b0;
    chk("t6_out_valid", dn_if.valid, 1);
    chk("t6_out_data", dn_if.data, W'(8'hD1));
    step();
    chk("t6_occ_end", occupancy, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
